// File: rtl/set_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// set_scan_ctrl_pkg
// Shared definitions for the SET grid-scan sequencer:
//   - default grid dimensions (GRID_W_DEF x GRID_H_DEF)
//   - COORD_SZ: width of one coordinate field (x or y) at the coord_gen port
//   - state_t : 3-bit FSM encoding used by set_scan_ctrl
//   - max_int : elaboration-time helper for sizing shared counters
// ----------------------------------------------------------------------------
package set_scan_ctrl_pkg;

    localparam int GRID_W_DEF = 8;
    localparam int GRID_H_DEF = 8;
    localparam int COORD_SZ   = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/set_scan_ctrl_hit_pipe.sv
// ----------------------------------------------------------------------------
// set_hit_pipe
// HIT_LAT-deep delay line for the coordinate-valid flag, plus the hit
// counter it gates. A hit is counted only when the flag emerging from the
// tail says the result on i_hit belongs to a coordinate of the scan.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (clears pipe and count)
//   i_flush  synchronous abort: empties the pipe, count holds its value
//   i_start  synchronous count clear at scan acceptance
//   i_valid  coordinate-valid flag entering the pipe
//   i_hit    in-circle result aligned with the pipe tail
//   o_count  accumulated hit count (saturating)
// ----------------------------------------------------------------------------
module set_hit_pipe #(
    parameter int HIT_LAT = 2,
    parameter int CNT_W   = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic             i_hit,
    output logic [CNT_W-1:0] o_count
);

    logic             w_tail;
    logic [CNT_W-1:0] r_count;

    genvar gi;
    generate
        for (gi = 0; gi < HIT_LAT; gi++) begin : g_stage
            logic w_d;
            logic r_bit;

            if (gi == 0) begin : g_head
                assign w_d = i_valid;
            end else begin : g_link
                assign w_d = g_stage[gi-1].r_bit;
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_bit <= 1'b0;
                end else if (i_flush) begin
                    r_bit <= 1'b0;
                end else begin
                    r_bit <= w_d;
                end
            end
        end
    endgenerate

    assign w_tail = g_stage[HIT_LAT-1].r_bit;

    // Flush wins over counting so a hit arriving in the abort cycle is dropped;
    // the partial count itself is kept for inspection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= r_count;
        end else if (i_start) begin
            r_count <= '0;
        end else if (w_tail && i_hit && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/set_scan_ctrl.sv
// ----------------------------------------------------------------------------
// set_scan_ctrl
// Sequencer for the SET grid scan. Walks rows 1..GRID_H, issuing one
// coord_gen load per row followed by GRID_W valid coordinate cycles, waits
// HIT_LAT cycles for the last in-circle results, then pulses valid_o with
// the final hit count.
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-low reset
//   en_i           start request, honoured only in IDLE
//   clear_i        synchronous abort back to IDLE (no result)
//   hit_i          in-circle result, HIT_LAT cycles after its coordinate
//   coord_en_o     load pulse to coord_gen (x<=1, y<=start_row_o)
//   start_row_o    row to load, meaningful while coord_en_o=1
//   coord_valid_o  coordinate at coord_gen output belongs to the scan
//   busy_o         scan in progress
//   valid_o        one-cycle pulse, candidate_o is final
//   candidate_o    hit count, held until the next accepted en_i
// All outputs are registered decodes of the state, so each appears one
// cycle after the state that produces it.
// ----------------------------------------------------------------------------
module set_scan_ctrl
    import set_scan_ctrl_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int HIT_LAT = 2,
    parameter int CNT_W   = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic                hit_i,
    output logic                coord_en_o,
    output logic [COORD_SZ-1:0] start_row_o,
    output logic                coord_valid_o,
    output logic                busy_o,
    output logic                valid_o,
    output logic [CNT_W-1:0]    candidate_o
);

    localparam int ROW_W = $clog2(GRID_H + 1);
    // The column counter doubles as the drain counter.
    localparam int COL_W = $clog2(max_int(GRID_W, HIT_LAT) + 1);

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(GRID_H);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(GRID_W);
    localparam logic [COL_W-1:0] DRAIN_LAST = COL_W'(HIT_LAT);

    state_t              r_state;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic                r_coord_en;
    logic [COORD_SZ-1:0] r_start_row;
    logic                r_coord_valid;
    logic                r_busy;
    logic                r_valid;
    logic                w_start;

    assign w_start = (r_state == S_IDLE) && en_i && !clear_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_coord_en    <= 1'b0;
            r_start_row   <= '0;
            r_coord_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
        end else if (clear_i) begin
            // Abort drops everything at once, including outputs already
            // scheduled from the current state.
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_coord_en    <= 1'b0;
            r_start_row   <= '0;
            r_coord_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_coord_en    <= (r_state == S_LOAD);
            r_start_row   <= (r_state == S_LOAD) ? COORD_SZ'(r_row) : '0;
            r_coord_valid <= (r_state == S_SCAN);
            r_busy        <= (r_state != S_IDLE);
            r_valid       <= (r_state == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (en_i) begin
                        r_state <= S_LOAD;
                        r_row   <= ROW_W'(1);
                    end
                end
                S_LOAD: begin
                    r_col   <= COL_W'(1);
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (r_col == COL_LAST) begin
                        if (r_row < ROW_LAST) begin
                            r_row   <= r_row + 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_col   <= COL_W'(1);
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // After HIT_LAT cycles the last scan coordinate has
                    // reached the pipe tail, so the pipe is empty next cycle.
                    if (r_col == DRAIN_LAST) begin
                        r_col   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_DONE: begin
                    r_row   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_row   <= '0;
                    r_col   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    set_hit_pipe #(
        .HIT_LAT (HIT_LAT),
        .CNT_W   (CNT_W)
    ) u_hit_pipe (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_flush (clear_i),
        .i_start (w_start),
        .i_valid (r_coord_valid),
        .i_hit   (hit_i),
        .o_count (candidate_o)
    );

    assign coord_en_o    = r_coord_en;
    assign start_row_o   = r_start_row;
    assign coord_valid_o = r_coord_valid;
    assign busy_o        = r_busy;
    assign valid_o       = r_valid;

endmodule

// File: tb/tb_set_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_set_scan_ctrl
// Directed bench for set_scan_ctrl. A small coord_gen model reacts to
// coord_en_o and produces hit_i per test mode; each accepted scan pushes its
// expected completion cycle and count onto a scoreboard that is popped when
// valid_o appears. Cycle k of a scan is the cycle starting k edges after
// the edge that sampled en_i.
// ----------------------------------------------------------------------------
module tb_set_scan_ctrl;

    localparam int GW       = 8;
    localparam int GH       = 8;
    localparam int HL       = 2;
    localparam int CW       = 7;
    localparam int ROW_P    = GW + 1;          // one load bubble per row
    localparam int SCAN_LEN = GH * ROW_P;      // 72
    localparam int LAT      = 1 + SCAN_LEN + HL; // 75
    localparam int PERIOD   = LAT + 1;         // 76

    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b0;
    logic          en_i    = 1'b0;
    logic          clear_i = 1'b0;
    logic          hit_i   = 1'b0;
    logic          coord_en_o;
    logic [3:0]    start_row_o;
    logic          coord_valid_o;
    logic          busy_o;
    logic          valid_o;
    logic [CW-1:0] candidate_o;

    set_scan_ctrl #(
        .GRID_W  (GW),
        .GRID_H  (GH),
        .HIT_LAT (HL),
        .CNT_W   (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .clear_i       (clear_i),
        .hit_i         (hit_i),
        .coord_en_o    (coord_en_o),
        .start_row_o   (start_row_o),
        .coord_valid_o (coord_valid_o),
        .busy_o        (busy_o),
        .valid_o       (valid_o),
        .candidate_o   (candidate_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int due;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t0    = -1000;
    bit   track = 1'b0;
    int   mode  = 0;      // 0 all-hit, 1 x==y, 2 hit only off-tail
    int   sched_err = 0;
    int   n_load = 0;
    int   n_cv   = 0;
    int   mx = 0;
    int   my = 0;
    int   hx[HL+1];
    int   hy[HL+1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit sched_ce(input int k);
        return (k >= 1) && (k <= SCAN_LEN) && (((k - 1) % ROW_P) == 0);
    endfunction

    function automatic bit sched_cv(input int k);
        return (k >= 1) && (k <= SCAN_LEN) && (((k - 1) % ROW_P) != 0);
    endfunction

    // One clock cycle: advance the coord_gen model, observe outputs #1 after
    // the edge, feed the scoreboard, then drive hit_i for the new cycle.
    task automatic tick();
        bit   pe;
        int   prow;
        int   k;
        exp_t e;
        pe   = (coord_en_o === 1'b1);
        prow = int'(start_row_o);
        @(posedge clk_i);
        cyc++;
        if (pe) begin
            mx = 1;
            my = prow;
        end else begin
            mx = mx + 1;
        end
        for (int i = HL; i > 0; i--) begin
            hx[i] = hx[i-1];
            hy[i] = hy[i-1];
        end
        hx[0] = mx;
        hy[0] = my;
        #1;
        k = cyc - t0;
        if (track && k >= 1 && k <= PERIOD) begin
            if (coord_en_o !== sched_ce(k)) sched_err++;
            if (coord_en_o === 1'b1) begin
                n_load++;
                if (int'(start_row_o) != (k - 1) / ROW_P + 1) sched_err++;
            end
            if (coord_valid_o !== sched_cv(k)) sched_err++;
            if (coord_valid_o === 1'b1) n_cv++;
            if (busy_o !== (k <= LAT)) sched_err++;
        end
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", valid_o, 0);
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle", cyc, e.due);
                check("candidate", candidate_o, e.cnt);
                check("busy_in_done", busy_o, 1);
            end
        end
        case (mode)
            0:       hit_i = 1'b1;
            1:       hit_i = (hx[HL] == hy[HL]);
            default: hit_i = !sched_cv(k - HL);
        endcase
    endtask

    task automatic begin_track();
        t0        = cyc;
        track     = 1'b1;
        sched_err = 0;
        n_load    = 0;
        n_cv      = 0;
    endtask

    task automatic start_scan(input int m, input int expc);
        exp_t e;
        mode = m;
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        begin_track();
        e.due = t0 + LAT;
        e.cnt = expc;
        exp_q.push_back(e);
    endtask

    task automatic run_to(input int k_end);
        while (cyc < t0 + k_end) tick();
    endtask

    task automatic scan_checks(input string tag);
        check({tag, "_schedule"}, sched_err, 0);
        check({tag, "_loads"}, n_load, GH);
        check({tag, "_valid_coords"}, n_cv, GH * GW);
    endtask

    task automatic finish_scan(input string tag, input int expc);
        scan_checks(tag);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_cand_held"}, candidate_o, expc);
        track = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        // Reset state
        repeat (3) tick();
        check("rst_coord_en", coord_en_o, 0);
        check("rst_start_row", start_row_o, 0);
        check("rst_coord_valid", coord_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_candidate", candidate_o, 0);
        rst_i = 1'b1;
        repeat (3) tick();
        check("idle_busy", busy_o, 0);

        // All-hit scan
        start_scan(0, GW * GH);
        run_to(PERIOD);
        finish_scan("allhit", GW * GH);
        repeat (4) tick();

        // Diagonal pattern: one hit per row; idle coordinate (0,0) also hits
        start_scan(1, GH);
        run_to(PERIOD);
        finish_scan("diag", GH);
        repeat (4) tick();

        // Spurious hits only where the pipe tail is empty
        mode = 2;
        repeat (4) tick();
        start_scan(2, 0);
        run_to(PERIOD);
        finish_scan("spurious", 0);
        repeat (4) tick();

        // Abort at edge 30: tails in cycles 4..11, 13..20, 22..28 counted = 23
        start_scan(0, GW * GH);
        run_to(29);
        check("abort_schedule", sched_err, 0);
        track   = 1'b0;
        hit_i   = 1'b0;
        clear_i = 1'b1;
        en_i    = 1'b1;
        void'(exp_q.pop_back());
        tick();
        clear_i = 1'b0;
        en_i    = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_coord_valid", coord_valid_o, 0);
        check("abort_coord_en", coord_en_o, 0);
        check("abort_partial", candidate_o, 23);
        repeat (10) tick();
        check("abort_idle_busy", busy_o, 0);
        start_scan(1, GH);
        run_to(PERIOD);
        finish_scan("post_abort", GH);
        repeat (4) tick();

        // en_i held high: back-to-back scans every PERIOD cycles
        mode = 0;
        en_i = 1'b1;
        tick();
        begin_track();
        e.due = t0 + LAT;
        e.cnt = GW * GH;
        exp_q.push_back(e);
        e.due = t0 + PERIOD + LAT;
        exp_q.push_back(e);
        run_to(PERIOD);
        scan_checks("retrig1");
        begin_track();
        run_to(LAT);
        en_i = 1'b0;
        run_to(PERIOD);
        finish_scan("retrig2", GW * GH);
        repeat (10) tick();
        check("retrig_idle_busy", busy_o, 0);

        // Async reset during DRAIN
        start_scan(0, GW * GH);
        run_to(73);
        track = 1'b0;
        void'(exp_q.pop_back());
        rst_i = 1'b0;
        #1;
        check("mrst_coord_valid", coord_valid_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_valid", valid_o, 0);
        check("mrst_candidate", candidate_o, 0);
        repeat (3) tick();
        rst_i = 1'b1;
        repeat (90) tick();
        check("mrst_idle_busy", busy_o, 0);
        check("mrst_idle_candidate", candidate_o, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/set_scan_ctrl.md
Name: set_scan_ctrl

Overview:
- Sequencer for the SET grid-scan datapath. It drives the coordinate generator row by row over a GRID_W x GRID_H grid with 1-based coordinates.
- It tracks the fixed-latency hit result from the in-circle test and accumulates the hit count.
- It reports the final candidate count with a one-cycle valid pulse.
- It sits between the top-level host handshake (en_i/busy_o/valid_o) and the coord_gen + circle-test datapath.

Parameters:
- GRID_W, 8, columns per row; x runs 1..GRID_W.
- GRID_H, 8, rows per scan; y runs 1..GRID_H.
- HIT_LAT, 2, cycles from a coordinate being presented to its hit_i being valid; range 1..4.
- CNT_W, 7, candidate counter width; must hold GRID_W*GRID_H.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- en_i  in  1  start request; sampled only in IDLE
- clear_i  in  1  synchronous abort; returns to IDLE, no result
- hit_i  in  1  in-circle result for the coordinate presented HIT_LAT cycles earlier
- coord_en_o  out  1  one-cycle load pulse to coord_gen: x<=1, y<=start_row_o
- start_row_o  out  4  row to load; valid when coord_en_o=1
- coord_valid_o  out  1  the coordinate currently at coord_gen output is part of the scan
- busy_o  out  1  scan in progress (LOAD/SCAN/DRAIN/DONE)
- valid_o  out  1  one-cycle pulse; candidate_o is final
- candidate_o  out  CNT_W  hit count; held after DONE until next accepted en_i

Behaviour:
- Reset (rst_i=0, async): state IDLE, row/col counters 0, hit pipe cleared. All outputs 0.
- Coordinate timing contract: coord_gen shows x=1 of start_row in the cycle after coord_en_o, then x+1 each cycle.
- IDLE:
  - en_i=1 -> LOAD with row=1, candidate_o cleared to 0, busy_o=1 from the next cycle.
  - en_i while not IDLE is ignored.
- LOAD (1 cycle):
  - coord_en_o=1, start_row_o=row, coord_valid_o=0, col<=1.
  - -> SCAN.
- SCAN (GRID_W cycles):
  - coord_valid_o=1, col increments each cycle.
  - At col==GRID_W: if row<GRID_H, row+1 and -> LOAD (one bubble per row); else -> DRAIN.
- DRAIN (HIT_LAT cycles):
  - coord_valid_o=0.
  - Wait until the hit pipe is empty, then -> DONE.
- DONE (1 cycle):
  - valid_o=1, candidate_o final.
  - -> IDLE; busy_o falls the next cycle.
- Hit accounting:
  - coord_valid_o feeds a HIT_LAT-deep valid shift register.
  - When the tail bit is 1 and hit_i=1, candidate_o+1.
  - hit_i is ignored when the tail is 0, including in IDLE.
- Latency: valid_o is high in the cycle starting 1 + GRID_H*(GRID_W+1) + HIT_LAT edges after the edge that sampled en_i. Default is 75.
- Counter saturates at 2^CNT_W-1; this cannot occur with legal parameters.
- clear_i has priority over every transition:
  - Next cycle state IDLE and hit pipe flushed.
  - No valid_o; candidate_o keeps its partial value.
  - en_i in the same cycle as clear_i is ignored.
- en_i in the DONE cycle is ignored; a new scan needs en_i in IDLE.
- Async reset mid-scan: immediate return to reset values; no valid_o.

Decomposition:
- Shared def.v:
  - GRID_W/GRID_H defaults
  - X_COORD/Y_COORD field macros, COORD_SZ
  - 3-bit state encodings S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_DONE
- Sub-module set_hit_pipe: parameterised HIT_LAT valid delay line plus gated hit counter with clear.
- The FSM and row/col counters stay in set_scan_ctrl.

Test Plan:
- All-hit: hit_i=1 constantly, en_i pulse -> 8 coord_en_o pulses with start_row_o=1..8, 64 coord_valid_o cycles; valid_o at edge 75; candidate_o=64.
- Pattern: bench model sets hit=1 only where x==y (delayed HIT_LAT) -> candidate_o=8. coord_valid_o low exactly on the 8 LOAD cycles and 2 DRAIN cycles.
- Spurious hits: hit_i=1 only while the pipe tail is 0 (IDLE, LOAD-aligned slots, DONE) -> candidate_o=0; valid_o still at edge 75.
- Abort: clear_i at edge 30 -> IDLE next cycle, busy_o=0, no valid_o. A new en_i gives a full 75-cycle scan with a fresh count.
- Re-trigger: en_i held high throughout -> one valid_o per 76-cycle period, not restarted mid-scan. candidate_o is cleared at each acceptance.
- Reset mid-DRAIN: rst_i low at edge 73 -> all outputs 0 immediately, no valid_o. After release, IDLE awaits en_i.
